// File: rtl/id_ex_hazard_ctrl.sv
// ID/EX pipeline register with load-use hazard detection and EX-stage
// conditional branch resolution. Drives the fetch/decode front-end
// controls (PC_write, IF_ID_write, PCSrc, PC_Branch, IF_ID_flush) and
// keeps saturating counters of stall and flush events.
module id_ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      PC_ID,
    input  logic [31:0]      IMM_ID,
    input  logic [31:0]      REG_DATA1_ID,
    input  logic [31:0]      REG_DATA2_ID,
    input  logic [6:0]       OPCODE_ID,
    input  logic [2:0]       FUNCT3_ID,
    input  logic [4:0]       RD_ID,
    input  logic [4:0]       RS1_ID,
    input  logic [4:0]       RS2_ID,
    input  logic [31:0]      BR_OP1_EX,
    input  logic [31:0]      BR_OP2_EX,
    output logic             PC_write,
    output logic             IF_ID_write,
    output logic             IF_ID_flush,
    output logic             PCSrc,
    output logic [31:0]      PC_Branch,
    output logic [31:0]      PC_EX,
    output logic [31:0]      IMM_EX,
    output logic [31:0]      REG_DATA1_EX,
    output logic [31:0]      REG_DATA2_EX,
    output logic [4:0]       RD_EX,
    output logic [2:0]       FUNCT3_EX,
    output logic [6:0]       OPCODE_EX,
    output logic             VALID_EX,
    output logic             MemRead_EX,
    output logic             RegWrite_EX,
    output logic [CNT_W-1:0] STALL_CNT,
    output logic [CNT_W-1:0] FLUSH_CNT
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Instruction reads rs1
    function automatic logic f_uses_rs1(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction reads rs2
    function automatic logic f_uses_rs2(input logic [6:0] op);
        case (op)
            OP_R, OP_STORE, OP_BRANCH: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Instruction writes rd
    function automatic logic f_reg_write(input logic [6:0] op);
        case (op)
            OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Branch condition by funct3; reserved encodings never branch
    function automatic logic f_br_cond(input logic [2:0] f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
        case (f3)
            3'b000:  return (a == b);
            3'b001:  return (a != b);
            3'b100:  return ($signed(a) <  $signed(b));
            3'b101:  return ($signed(a) >= $signed(b));
            3'b110:  return (a <  b);
            3'b111:  return (a >= b);
            default: return 1'b0;
        endcase
    endfunction

    logic taken_s;
    logic load_use_s;
    logic bubble_s;
    logic rs1_hit_s;
    logic rs2_hit_s;

    // Hazard and branch resolution; a taken branch overrides the stall
    always_comb begin
        taken_s    = 1'b0;
        load_use_s = 1'b0;
        rs1_hit_s  = f_uses_rs1(OPCODE_ID) & (RD_EX == RS1_ID);
        rs2_hit_s  = f_uses_rs2(OPCODE_ID) & (RD_EX == RS2_ID);
        if (VALID_EX && (OPCODE_EX == OP_BRANCH)) begin
            taken_s = f_br_cond(FUNCT3_EX, BR_OP1_EX, BR_OP2_EX);
        end else begin
            taken_s = 1'b0;
        end
        if (VALID_EX && MemRead_EX && (RD_EX != 5'd0)) begin
            load_use_s = rs1_hit_s | rs2_hit_s;
        end else begin
            load_use_s = 1'b0;
        end
        bubble_s    = taken_s | load_use_s;
        PCSrc       = taken_s;
        IF_ID_flush = taken_s;
        PC_Branch   = PC_EX + IMM_EX;
        PC_write    = ~load_use_s | taken_s;
        IF_ID_write = ~load_use_s | taken_s;
    end

    // ID/EX register: bubble on flush or stall, otherwise capture decode
    always_ff @(posedge clk) begin
        if (reset || bubble_s) begin
            PC_EX        <= 32'd0;
            IMM_EX       <= 32'd0;
            REG_DATA1_EX <= 32'd0;
            REG_DATA2_EX <= 32'd0;
            RD_EX        <= 5'd0;
            FUNCT3_EX    <= 3'd0;
            OPCODE_EX    <= 7'd0;
            VALID_EX     <= 1'b0;
            MemRead_EX   <= 1'b0;
            RegWrite_EX  <= 1'b0;
        end else begin
            PC_EX        <= PC_ID;
            IMM_EX       <= IMM_ID;
            REG_DATA1_EX <= REG_DATA1_ID;
            REG_DATA2_EX <= REG_DATA2_ID;
            RD_EX        <= RD_ID;
            FUNCT3_EX    <= FUNCT3_ID;
            OPCODE_EX    <= OPCODE_ID;
            VALID_EX     <= 1'b1;
            MemRead_EX   <= (OPCODE_ID == OP_LOAD);
            RegWrite_EX  <= f_reg_write(OPCODE_ID);
        end
    end

    // Saturating stall counter; a stall masked by a taken branch is not counted
    always_ff @(posedge clk) begin
        if (reset) begin
            STALL_CNT <= {CNT_W{1'b0}};
        end else if (load_use_s && !taken_s && (STALL_CNT != CNT_MAX)) begin
            STALL_CNT <= STALL_CNT + CNT_ONE;
        end else begin
            STALL_CNT <= STALL_CNT;
        end
    end

    // Saturating flush counter
    always_ff @(posedge clk) begin
        if (reset) begin
            FLUSH_CNT <= {CNT_W{1'b0}};
        end else if (taken_s && (FLUSH_CNT != CNT_MAX)) begin
            FLUSH_CNT <= FLUSH_CNT + CNT_ONE;
        end else begin
            FLUSH_CNT <= FLUSH_CNT;
        end
    end

endmodule

// File: tb/tb_id_ex_hazard_ctrl.sv
// Directed bench for id_ex_hazard_ctrl: a behavioural model is checked
// against the DUT every cycle, plus hand-computed literal checks.
module tb_id_ex_hazard_ctrl;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic        clk, reset;
    logic [31:0] PC_ID, IMM_ID, REG_DATA1_ID, REG_DATA2_ID, BR_OP1_EX, BR_OP2_EX;
    logic [6:0]  OPCODE_ID;
    logic [2:0]  FUNCT3_ID;
    logic [4:0]  RD_ID, RS1_ID, RS2_ID;

    logic        PC_write, IF_ID_write, IF_ID_flush, PCSrc;
    logic [31:0] PC_Branch, PC_EX, IMM_EX, REG_DATA1_EX, REG_DATA2_EX;
    logic [4:0]  RD_EX;
    logic [2:0]  FUNCT3_EX;
    logic [6:0]  OPCODE_EX;
    logic        VALID_EX, MemRead_EX, RegWrite_EX;
    logic [15:0] STALL_CNT, FLUSH_CNT;

    logic        d2_pcw, d2_ifw, d2_fl, d2_src, d2_v, d2_mr, d2_rw;
    logic [31:0] d2_pcb, d2_pc, d2_imm, d2_d1, d2_d2;
    logic [4:0]  d2_rd;
    logic [2:0]  d2_f3;
    logic [6:0]  d2_op;
    logic [1:0]  d2_stall, d2_flush;

    id_ex_hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
        .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
        .OPCODE_ID(OPCODE_ID), .FUNCT3_ID(FUNCT3_ID), .RD_ID(RD_ID),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .BR_OP1_EX(BR_OP1_EX), .BR_OP2_EX(BR_OP2_EX),
        .PC_write(PC_write), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .PCSrc(PCSrc), .PC_Branch(PC_Branch), .PC_EX(PC_EX), .IMM_EX(IMM_EX),
        .REG_DATA1_EX(REG_DATA1_EX), .REG_DATA2_EX(REG_DATA2_EX), .RD_EX(RD_EX),
        .FUNCT3_EX(FUNCT3_EX), .OPCODE_EX(OPCODE_EX), .VALID_EX(VALID_EX),
        .MemRead_EX(MemRead_EX), .RegWrite_EX(RegWrite_EX),
        .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
    );

    id_ex_hazard_ctrl #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .PC_ID(PC_ID), .IMM_ID(IMM_ID),
        .REG_DATA1_ID(REG_DATA1_ID), .REG_DATA2_ID(REG_DATA2_ID),
        .OPCODE_ID(OPCODE_ID), .FUNCT3_ID(FUNCT3_ID), .RD_ID(RD_ID),
        .RS1_ID(RS1_ID), .RS2_ID(RS2_ID), .BR_OP1_EX(BR_OP1_EX), .BR_OP2_EX(BR_OP2_EX),
        .PC_write(d2_pcw), .IF_ID_write(d2_ifw), .IF_ID_flush(d2_fl),
        .PCSrc(d2_src), .PC_Branch(d2_pcb), .PC_EX(d2_pc), .IMM_EX(d2_imm),
        .REG_DATA1_EX(d2_d1), .REG_DATA2_EX(d2_d2), .RD_EX(d2_rd),
        .FUNCT3_EX(d2_f3), .OPCODE_EX(d2_op), .VALID_EX(d2_v),
        .MemRead_EX(d2_mr), .RegWrite_EX(d2_rw),
        .STALL_CNT(d2_stall), .FLUSH_CNT(d2_flush)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit armed = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The EX slot holds either nothing (bubble) or a snapshot of one decoded instruction.
    logic        m_valid, m_mr, m_rw;
    logic [4:0]  m_rd;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic [31:0] m_pc, m_imm, m_d1, m_d2;
    int          m_stalls, m_flushes;
    bit          mt, mlu;

    function automatic bit model_taken();
        longint sa, sb;
        if (!m_valid || m_op != OP_BR) return 1'b0;
        sa = longint'($signed(BR_OP1_EX));
        sb = longint'($signed(BR_OP2_EX));
        case (m_f3)
            3'd0: return BR_OP1_EX == BR_OP2_EX;
            3'd1: return BR_OP1_EX != BR_OP2_EX;
            3'd4: return sa < sb;
            3'd5: return !(sa < sb);
            3'd6: return longint'(BR_OP1_EX) < longint'(BR_OP2_EX);
            3'd7: return !(longint'(BR_OP1_EX) < longint'(BR_OP2_EX));
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_load_use();
        bit r1, r2;
        r1 = OPCODE_ID inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1100111};
        r2 = OPCODE_ID inside {7'b0110011, 7'b0100011, 7'b1100011};
        if (!(m_valid && m_mr) || m_rd == 5'd0) return 1'b0;
        return (r1 && m_rd == RS1_ID) || (r2 && m_rd == RS2_ID);
    endfunction

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    always @(posedge clk) begin
        mt  = model_taken();
        mlu = model_load_use();
        if (reset || mt || mlu) begin
            m_valid <= 1'b0; m_mr <= 1'b0; m_rw <= 1'b0; m_rd <= 5'd0; m_op <= 7'd0;
            m_f3 <= 3'd0; m_pc <= 32'd0; m_imm <= 32'd0; m_d1 <= 32'd0; m_d2 <= 32'd0;
        end else begin
            m_valid <= 1'b1;
            m_mr    <= (OPCODE_ID == OP_LD);
            m_rw    <= OPCODE_ID inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b1101111,
                                         7'b1100111, 7'b0110111, 7'b0010111};
            m_rd <= RD_ID; m_op <= OPCODE_ID; m_f3 <= FUNCT3_ID;
            m_pc <= PC_ID; m_imm <= IMM_ID; m_d1 <= REG_DATA1_ID; m_d2 <= REG_DATA2_ID;
        end
        if (reset) begin
            m_stalls  <= 0;
            m_flushes <= 0;
        end else begin
            m_stalls  <= m_stalls + ((mlu && !mt) ? 1 : 0);
            m_flushes <= m_flushes + (mt ? 1 : 0);
        end
    end

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (armed) begin
            bit t, lu;
            t  = model_taken();
            lu = model_load_use();
            chk("PCSrc",       {31'd0, PCSrc},       {31'd0, t});
            chk("IF_ID_flush", {31'd0, IF_ID_flush}, {31'd0, t});
            chk("PC_write",    {31'd0, PC_write},    {31'd0, (!lu || t)});
            chk("IF_ID_write", {31'd0, IF_ID_write}, {31'd0, (!lu || t)});
            chk("PC_Branch",   PC_Branch,            m_pc + m_imm);
            chk("VALID_EX",    {31'd0, VALID_EX},    {31'd0, m_valid});
            chk("MemRead_EX",  {31'd0, MemRead_EX},  {31'd0, m_mr});
            chk("RegWrite_EX", {31'd0, RegWrite_EX}, {31'd0, m_rw});
            chk("RD_EX",       {27'd0, RD_EX},       {27'd0, m_rd});
            chk("OPCODE_EX",   {25'd0, OPCODE_EX},   {25'd0, m_op});
            chk("FUNCT3_EX",   {29'd0, FUNCT3_EX},   {29'd0, m_f3});
            chk("PC_EX",       PC_EX,                m_pc);
            chk("IMM_EX",      IMM_EX,               m_imm);
            chk("REG_DATA1_EX", REG_DATA1_EX,        m_d1);
            chk("REG_DATA2_EX", REG_DATA2_EX,        m_d2);
            chk("STALL_CNT",   {16'd0, STALL_CNT},   32'(sat(m_stalls, 16)));
            chk("FLUSH_CNT",   {16'd0, FLUSH_CNT},   32'(sat(m_flushes, 16)));
            chk("STALL_CNT_W2", {30'd0, d2_stall},   32'(sat(m_stalls, 2)));
            chk("FLUSH_CNT_W2", {30'd0, d2_flush},   32'(sat(m_flushes, 2)));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_id(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] pc, input logic [31:0] imm);
        OPCODE_ID = op; FUNCT3_ID = f3; RD_ID = rd; RS1_ID = rs1; RS2_ID = rs2;
        PC_ID = pc; IMM_ID = imm;
        REG_DATA1_ID = pc ^ 32'hA5A5_0000; REG_DATA2_ID = imm ^ 32'h0000_5A5A;
    endtask

    task automatic nop();
        set_id(OP_I, 3'd0, 5'd0, 5'd0, 5'd0, 32'h100, 32'd0);
    endtask

    logic [2:0] br_f3 [4];
    logic       br_exp [4];

    initial begin
        br_f3  = '{3'd4, 3'd6, 3'd5, 3'd7};   // blt, bltu, bge, bgeu
        br_exp = '{1'b1, 1'b0, 1'b0, 1'b1};

        // Reset for two cycles with arbitrary decode inputs
        reset = 1'b1;
        set_id(7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
               $urandom, $urandom);
        BR_OP1_EX = $urandom; BR_OP2_EX = $urandom;
        step();
        step();
        armed = 1'b1;
        reset = 1'b0;
        set_id(OP_LD, 3'd2, 5'd5, 5'd1, 5'd0, 32'h0, 32'h0);          // lw x5,0(x1)
        mid();
        chk("rst_VALID_EX", {31'd0, VALID_EX}, 32'd0);
        chk("rst_PC_EX", PC_EX, 32'd0);
        chk("rst_STALL_CNT", {16'd0, STALL_CNT}, 32'd0);
        chk("rst_FLUSH_CNT", {16'd0, FLUSH_CNT}, 32'd0);
        chk("rst_PC_write", {31'd0, PC_write}, 32'd1);
        chk("rst_IF_ID_write", {31'd0, IF_ID_write}, 32'd1);
        chk("rst_PCSrc", {31'd0, PCSrc}, 32'd0);

        // Load-use: lw x5 in EX, add x6,x5,x2 in ID
        step();
        set_id(OP_R, 3'd0, 5'd6, 5'd5, 5'd2, 32'h4, 32'h0);
        mid();
        chk("lu_PC_write", {31'd0, PC_write}, 32'd0);
        chk("lu_IF_ID_write", {31'd0, IF_ID_write}, 32'd0);
        step();
        mid();
        chk("lu_bubble_VALID", {31'd0, VALID_EX}, 32'd0);
        chk("lu_release_PC_write", {31'd0, PC_write}, 32'd1);
        chk("lu_STALL_CNT", {16'd0, STALL_CNT}, 32'd1);
        step();
        set_id(OP_LD, 3'd2, 5'd0, 5'd1, 5'd0, 32'h8, 32'h0);          // lw x0,0(x1)
        mid();
        chk("lu_add_VALID", {31'd0, VALID_EX}, 32'd1);
        chk("lu_add_RD", {27'd0, RD_EX}, 32'd6);

        // lw x0 then add x6,x0,x2: no stall
        step();
        set_id(OP_R, 3'd0, 5'd6, 5'd0, 5'd2, 32'hC, 32'h0);
        mid();
        chk("x0_PC_write", {31'd0, PC_write}, 32'd1);
        // lw x5 then addi with rs2 field = 5: no stall
        step();
        set_id(OP_LD, 3'd2, 5'd5, 5'd1, 5'd0, 32'h10, 32'h0);
        step();
        set_id(OP_I, 3'd0, 5'd7, 5'd3, 5'd5, 32'h14, 32'h1);
        mid();
        chk("itype_PC_write", {31'd0, PC_write}, 32'd1);

        // beq taken: PC 0x10 + 8
        step();
        set_id(OP_BR, 3'd0, 5'd0, 5'd1, 5'd2, 32'h10, 32'h8);
        BR_OP1_EX = 32'd7; BR_OP2_EX = 32'd7;
        step();
        nop();
        mid();
        chk("beq_PCSrc", {31'd0, PCSrc}, 32'd1);
        chk("beq_PC_Branch", PC_Branch, 32'h18);
        chk("beq_flush", {31'd0, IF_ID_flush}, 32'd1);
        step();
        set_id(OP_BR, 3'd0, 5'd0, 5'd1, 5'd2, 32'h10, 32'h8);
        mid();
        chk("beq_bubble_VALID", {31'd0, VALID_EX}, 32'd0);
        chk("beq_FLUSH_CNT", {16'd0, FLUSH_CNT}, 32'd1);
        step();
        nop();
        BR_OP2_EX = 32'd8;
        mid();
        chk("beq_nt_PCSrc", {31'd0, PCSrc}, 32'd0);
        step();

        // Signed vs unsigned compares of 0xFFFFFFFF against 1
        BR_OP1_EX = 32'hFFFF_FFFF; BR_OP2_EX = 32'd1;
        for (int i = 0; i < 4; i++) begin
            set_id(OP_BR, br_f3[i], 5'd0, 5'd1, 5'd2, 32'h40, 32'h10);
            step();
            nop();
            mid();
            chk($sformatf("cmp_f3_%0d", br_f3[i]), {31'd0, PCSrc}, {31'd0, br_exp[i]});
            step();
        end

        // Branch target wraps modulo 2^32
        set_id(OP_BR, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 32'h8);
        BR_OP1_EX = 32'd3; BR_OP2_EX = 32'd3;
        step();
        nop();
        mid();
        chk("wrap_PC_Branch", PC_Branch, 32'h4);
        chk("wrap_PCSrc", {31'd0, PCSrc}, 32'd1);
        step();

        // Taken branch whose rd field matches the ID source: branch wins, no stall
        set_id(OP_BR, 3'd0, 5'd5, 5'd1, 5'd2, 32'h0, 32'h20);
        step();
        set_id(OP_R, 3'd0, 5'd6, 5'd5, 5'd5, 32'h4, 32'h0);
        mid();
        chk("prio_PCSrc", {31'd0, PCSrc}, 32'd1);
        chk("prio_PC_write", {31'd0, PC_write}, 32'd1);
        chk("prio_IF_ID_write", {31'd0, IF_ID_write}, 32'd1);
        step();
        mid();
        chk("prio_bubble_VALID", {31'd0, VALID_EX}, 32'd0);
        chk("prio_STALL_CNT", {16'd0, STALL_CNT}, 32'd1);
        chk("flush5_FLUSH_CNT", {16'd0, FLUSH_CNT}, 32'd5);
        chk("flush5_W2_FLUSH_CNT", {30'd0, d2_flush}, 32'd3);

        // Two more flushes: narrow counter stays saturated
        step();
        for (int i = 0; i < 2; i++) begin
            set_id(OP_BR, 3'd1, 5'd0, 5'd1, 5'd2, 32'h80, 32'h4);
            BR_OP1_EX = 32'd1; BR_OP2_EX = 32'd2;
            step();
            nop();
            step();
        end
        mid();
        chk("flush7_FLUSH_CNT", {16'd0, FLUSH_CNT}, 32'd7);
        chk("flush7_W2_FLUSH_CNT", {30'd0, d2_flush}, 32'd3);
        chk("end_W2_STALL_CNT", {30'd0, d2_stall}, 32'd1);

        // Reset mid-operation clears everything
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        mid();
        chk("rst2_FLUSH_CNT", {16'd0, FLUSH_CNT}, 32'd0);
        chk("rst2_STALL_CNT", {16'd0, STALL_CNT}, 32'd0);
        chk("rst2_VALID_EX", {31'd0, VALID_EX}, 32'd0);
        step();

        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
